// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundles every signal between the pipeline sequencer and the 5-stage MIPS
//   datapath, except the scalar clock and reset.
//
//   Datapath -> sequencer:
//     start_i            CPU run enable (level)
//     IFID_Rs_i/Rt_i     rs/rt fields of the instruction in ID
//     IDEX_Rt_i          rt field of the instruction in EX
//     IDEX_MemRead_i     instruction in EX is a load
//     Branch_i/Equal_i   beq decoded in ID / ID-stage register compare
//     Jump_i             j decoded in ID
//     mem_req_i/ack_i    data-memory request / completion handshake
//   Sequencer -> datapath:
//     PC_en_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o  stage enables
//     IFID_flush_o       IF/ID loads a nop
//     IDEX_bubble_o      zero the control word entering ID/EX
//     PCsel_o            PC takes the branch/jump target
//     err_o              sticky memory-timeout error
//   Optional (macro PIPELINE_CTRL_PERF_EN): stall_cnt_o, flush_cnt_o.
//
//   Modport master = the sequencer, modport slave = the datapath side.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;
    logic       start_i;
    logic [4:0] IFID_Rs_i;
    logic [4:0] IFID_Rt_i;
    logic [4:0] IDEX_Rt_i;
    logic       IDEX_MemRead_i;
    logic       Branch_i;
    logic       Equal_i;
    logic       Jump_i;
    logic       mem_req_i;
    logic       mem_ack_i;

    logic       PC_en_o;
    logic       IFID_en_o;
    logic       IFID_flush_o;
    logic       IDEX_en_o;
    logic       IDEX_bubble_o;
    logic       EXMEM_en_o;
    logic       MEMWB_en_o;
    logic       PCsel_o;
    logic       err_o;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    modport master (
        input  start_i, IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_MemRead_i,
               Branch_i, Equal_i, Jump_i, mem_req_i, mem_ack_i,
        output PC_en_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o,
               EXMEM_en_o, MEMWB_en_o, PCsel_o, err_o, stall_cnt_o, flush_cnt_o
    );
    modport slave (
        output start_i, IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_MemRead_i,
               Branch_i, Equal_i, Jump_i, mem_req_i, mem_ack_i,
        input  PC_en_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o,
               EXMEM_en_o, MEMWB_en_o, PCsel_o, err_o, stall_cnt_o, flush_cnt_o
    );
`else
    modport master (
        input  start_i, IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_MemRead_i,
               Branch_i, Equal_i, Jump_i, mem_req_i, mem_ack_i,
        output PC_en_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o,
               EXMEM_en_o, MEMWB_en_o, PCsel_o, err_o
    );
    modport slave (
        output start_i, IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_MemRead_i,
               Branch_i, Equal_i, Jump_i, mem_req_i, mem_ack_i,
        input  PC_en_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o,
               EXMEM_en_o, MEMWB_en_o, PCsel_o, err_o
    );
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Sequencer for the 5-stage MIPS pipeline. Produces per-stage write enables,
//   the IF/ID flush, the ID/EX bubble and the PC source select from the ID
//   decode (branch/jump), the ID/EX load-use fields and a data-memory
//   request/ack handshake. Keeps the pipeline idle until start_i.
//
//   Ports:
//     clk_i   rising-edge clock
//     rst_i   synchronous active-high reset
//     bus     pipeline_ctrl_if.master (all handshake / control signals)
//
//   Parameters:
//     MEM_TIMEOUT  max MEMWAIT cycles without ack before err_o (1..255)
//     CNT_W        wait counter width, 2**CNT_W > MEM_TIMEOUT
//
//   Optional feature, macro PIPELINE_CTRL_PERF_EN:
//     stall_cnt_o  counts RUN/MEMWAIT cycles with PC_en_o = 0
//     flush_cnt_o  counts cycles with IFID_flush_o = 1
//   Both are 32-bit, cleared by rst_i, wrapping.
//
//   Only state, wait counter and err_o are registered; all other outputs are
//   combinational from state and inputs.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pipeline_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;

    logic load_use;
    logic taken;
    logic active;     // pipeline advances this cycle (RUN-style outputs)

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic exmem_en, memwb_en, pcsel;

    always_comb begin
        load_use = bus.IDEX_MemRead_i && (bus.IDEX_Rt_i != 5'd0) &&
                   ((bus.IDEX_Rt_i == bus.IFID_Rs_i) ||
                    (bus.IDEX_Rt_i == bus.IFID_Rt_i));
        taken    = (bus.Branch_i && bus.Equal_i) || bus.Jump_i;
    end

    // Next-state logic. "active" marks the cycles where the pipeline moves and
    // hazard/flush logic applies: RUN without a memory miss, or the ack cycle
    // that ends a MEMWAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        active  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.mem_req_i && !bus.mem_ack_i) begin
                    state_d = ST_MEMWAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    active = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                // Once the error is raised the pipeline stays frozen and later
                // acks are ignored until reset.
                if (!err_q) begin
                    if (bus.mem_ack_i) begin
                        active  = 1'b1;
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode. Load-use beats a taken transfer: the branch is
    // re-evaluated next cycle once the loaded value can be forwarded.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        pcsel       = 1'b0;
        if (active) begin
            pc_en       = !load_use;
            ifid_en     = !load_use;
            idex_en     = 1'b1;
            idex_bubble = load_use;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = taken && !load_use;
            pcsel       = taken && !load_use;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.PC_en_o       = pc_en;
    assign bus.IFID_en_o     = ifid_en;
    assign bus.IFID_flush_o  = ifid_flush;
    assign bus.IDEX_en_o     = idex_en;
    assign bus.IDEX_bubble_o = idex_bubble;
    assign bus.EXMEM_en_o    = exmem_en;
    assign bus.MEMWB_en_o    = memwb_en;
    assign bus.PCsel_o       = pcsel;
    assign bus.err_o         = err_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != ST_IDLE) && !pc_en) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (ifid_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Self-checking bench for pipeline_ctrl. Directed sequences for the listed
//   scenarios, then randomized traffic; every cycle the outputs are compared
//   against a behavioural model that tracks "running", "length of the current
//   memory stall" and "error" as plain variables.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int unsigned MEM_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    bit          m_run   = 1'b0;
    int          m_stall = 0;     // cycles the current memory access has been missing
    bit          m_err   = 1'b0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                         input logic mr, input logic br, input logic eq, input logic jp,
                         input logic rq, input logic ak);
        rst                = r;
        bus.start_i        = st;
        bus.IFID_Rs_i      = rs;
        bus.IFID_Rt_i      = rt;
        bus.IDEX_Rt_i      = xrt;
        bus.IDEX_MemRead_i = mr;
        bus.Branch_i       = br;
        bus.Equal_i        = eq;
        bus.Jump_i         = jp;
        bus.mem_req_i      = rq;
        bus.mem_ack_i      = ak;
    endtask

    // Check the current cycle against the model, advance the model, move to
    // the next cycle. Inputs must have been driven just before.
    task automatic step();
        logic [7:0] e_outs, g_outs;
        bit frozen, hz, tk;
        #4;
        e_outs = '0;
        frozen = 1'b1;
        if (m_run && !m_err) begin
            frozen = ((m_stall > 0) || bus.mem_req_i) && !bus.mem_ack_i;
            if (!frozen) begin
                hz = bus.IDEX_MemRead_i && (bus.IDEX_Rt_i != 0) &&
                     (bus.IDEX_Rt_i == bus.IFID_Rs_i || bus.IDEX_Rt_i == bus.IFID_Rt_i);
                tk = (bus.Branch_i && bus.Equal_i) || bus.Jump_i;
                // {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en, PCsel}
                e_outs = {!hz, !hz, tk && !hz, 1'b1, hz, 1'b1, 1'b1, tk && !hz};
            end
        end
        g_outs = {bus.PC_en_o, bus.IFID_en_o, bus.IFID_flush_o, bus.IDEX_en_o,
                  bus.IDEX_bubble_o, bus.EXMEM_en_o, bus.MEMWB_en_o, bus.PCsel_o};
        check("outs", {24'd0, g_outs}, {24'd0, e_outs});
        check("err",  {31'd0, bus.err_o}, {31'd0, m_err});
`ifdef PIPELINE_CTRL_PERF_EN
        check("stall_cnt", bus.stall_cnt_o, m_stall_cnt);
        check("flush_cnt", bus.flush_cnt_o, m_flush_cnt);
`endif
        $display("cyc %0d rst %b st %b mr %b xrt %0d rs %0d rt %0d br %b eq %b j %b req %b ack %b | outs %b err %b",
                 cyc, rst, bus.start_i, bus.IDEX_MemRead_i, bus.IDEX_Rt_i, bus.IFID_Rs_i,
                 bus.IFID_Rt_i, bus.Branch_i, bus.Equal_i, bus.Jump_i, bus.mem_req_i,
                 bus.mem_ack_i, g_outs, bus.err_o);

        if (rst) begin
            m_run = 0; m_stall = 0; m_err = 0;
            m_stall_cnt = '0; m_flush_cnt = '0;
        end else begin
            if (m_run && !e_outs[7]) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e_outs[5])           m_flush_cnt = m_flush_cnt + 32'd1;
            if (!m_run) begin
                m_run = bus.start_i;
            end else if (!m_err) begin
                if (frozen) begin
                    m_stall++;
                    // The missing RUN cycle plus MEM_TIMEOUT missing wait cycles
                    if (m_stall > MEM_TIMEOUT) m_err = 1;
                end else begin
                    m_stall = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic rand_step(input int p_rst, input int p_req, input int p_ack);
        drive(pct(p_rst), pct(30),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              pct(40), pct(30), pct(50), pct(10), pct(p_req), pct(p_ack));
        step();
    endtask

    // Quiet RUN cycle with distinct register numbers
    task automatic nop_step(input logic rq, input logic ak);
        drive(0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, rq, ak);
        step();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        // reset state, hazard inputs present but ignored
        drive(1, 0, 5'd8, 5'd8, 5'd8, 1, 1, 1, 1, 1, 0); step();
        drive(0, 0, 5'd8, 5'd8, 5'd8, 1, 1, 1, 1, 1, 0); step();
        // start for one cycle, then normal running
        drive(0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0); step();
        nop_step(0, 0);
        nop_step(0, 0);
        // load-use on rs, then rt=0 (no stall)
        drive(0, 0, 5'd8, 5'd2, 5'd8, 1, 0, 0, 0, 0, 0); step();
        nop_step(0, 0);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0); step();
        // branch taken, branch not taken, jump
        drive(0, 0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, 0, 0); step();
        drive(0, 0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 0); step();
        drive(0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0); step();
        // load-use on rt=9 together with a jump: the stall wins
        drive(0, 0, 5'd4, 5'd9, 5'd9, 1, 0, 0, 1, 0, 0); step();
        // ack without req is ignored; zero-wait access
        nop_step(0, 1);
        nop_step(1, 1);
        // memory wait: miss, 3 more missing cycles, then ack
        nop_step(1, 0);
        repeat (3) nop_step(0, 0);
        drive(0, 0, 5'd1, 5'd2, 5'd1, 1, 0, 0, 1, 0, 1); step();
        nop_step(0, 0);
        // wait ending exactly at the last allowed cycle
        nop_step(1, 0);
        repeat (MEM_TIMEOUT - 1) nop_step(0, 0);
        nop_step(0, 1);
        // timeout, a later ack is ignored, reset clears
        nop_step(1, 0);
        repeat (MEM_TIMEOUT + 3) nop_step(0, 0);
        repeat (2) nop_step(1, 1);
        drive(1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0); step();
        nop_step(0, 0);
        // random traffic, then long waits that hit the timeout
        repeat (400) rand_step(2, 25, 60);
        repeat (300) rand_step(3, 40, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
